// File: rtl/uc_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: FSM states,
// instruction field encodings, default word width and the legality decoder.
package uc_multiciclo_pkg;

  localparam int UC_XLEN = 64;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_REG    = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [2:0] F3_LD    = 3'b011;
  localparam logic [2:0] F3_SD    = 3'b011;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [6:0] F7_ADD   = 7'b0000000;
  localparam logic [6:0] F7_SUB   = 7'b0100000;

  typedef enum logic [2:0] {K_ILL, K_LD, K_SD, K_ADD, K_SUB} instr_kind_t;

  // Anything outside the four supported encodings classifies as K_ILL.
  function automatic instr_kind_t decode_kind(input logic [6:0] opcode,
                                              input logic [2:0] funct3,
                                              input logic [6:0] funct7);
    instr_kind_t k;
    k = K_ILL;
    if (opcode == OP_LOAD && funct3 == F3_LD)
      k = K_LD;
    else if (opcode == OP_STORE && funct3 == F3_SD)
      k = K_SD;
    else if (opcode == OP_OP && funct3 == F3_ADD && funct7 == F7_ADD)
      k = K_ADD;
    else if (opcode == OP_OP && funct3 == F3_ADD && funct7 == F7_SUB)
      k = K_SUB;
    return k;
  endfunction

endpackage

// File: rtl/uc_imm_gen.sv
// Immediate generator: picks the I- or S-type 12-bit field by instruction
// kind and sign-extends it to the datapath width; zero for register ops.
module uc_imm_gen
  import uc_multiciclo_pkg::*;
#(
  parameter int XLEN = UC_XLEN
) (
  input  instr_kind_t       i_kind,
  input  logic [11:0]       i_imm_i,
  input  logic [11:0]       i_imm_s,
  output logic [XLEN-1:0]   o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_kind)
      K_LD:    o_imm = {{(XLEN-12){i_imm_i[11]}}, i_imm_i};
      K_SD:    o_imm = {{(XLEN-12){i_imm_s[11]}}, i_imm_s};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for a 4-instruction subset (LD, SD, ADD, SUB):
// sequences fetch/decode/register/execute/memory and drives datapath controls.
module uc_multiciclo
  import uc_multiciclo_pkg::*;
#(
  parameter int XLEN    = UC_XLEN,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [XLEN-1:0]   pc,
  input  logic [31:0]       instr,
  output logic [XLEN-1:0]   Ra,
  output logic [XLEN-1:0]   Rb,
  output logic [XLEN-1:0]   Rw,
  output logic [XLEN-1:0]   C,
  output logic              we_reg,
  output logic              we_mem,
  output logic              sinal,
  output logic              sel_mux1,
  output logic              sel_mux2,
  output logic              busy,
  output logic              illegal
);

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic            r_illegal;

  instr_kind_t     w_fetch_kind;
  instr_kind_t     w_kind;
  logic [XLEN-1:0] w_pc_next;
  logic            w_rd_nz;

  // Legality is judged on the ROM word in DECODE, the same cycle it is latched.
  assign w_fetch_kind = decode_kind(instr[6:0], instr[14:12], instr[31:25]);
  assign w_kind       = decode_kind(r_ir[6:0], r_ir[14:12], r_ir[31:25]);
  assign w_pc_next    = r_pc + XLEN'(PC_STEP);
  assign w_rd_nz      = |r_ir[11:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   if (start) r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_ir <= instr;
          if (w_fetch_kind == K_ILL) begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end else begin
            r_state <= S_REG;
          end
        end
        S_REG:    r_state <= S_EXEC;
        S_EXEC: begin
          if (w_kind == K_LD) begin
            r_state <= S_MEM;
          end else begin
            r_pc    <= w_pc_next;
            r_state <= S_FETCH;
          end
        end
        S_MEM: begin
          r_pc    <= w_pc_next;
          r_state <= S_FETCH;
        end
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  uc_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_kind  (w_kind),
    .i_imm_i (r_ir[31:20]),
    .i_imm_s ({r_ir[31:25], r_ir[11:7]}),
    .o_imm   (C)
  );

  assign pc       = r_pc;
  assign illegal  = r_illegal;
  assign Ra       = {{(XLEN-5){1'b0}}, r_ir[19:15]};
  assign Rb       = {{(XLEN-5){1'b0}}, r_ir[24:20]};
  assign Rw       = {{(XLEN-5){1'b0}}, r_ir[11:7]};
  assign sinal    = (w_kind == K_SUB);
  assign sel_mux1 = (w_kind == K_ADD) || (w_kind == K_SUB);
  assign sel_mux2 = (w_kind != K_LD);
  assign busy     = (r_state != S_IDLE) && (r_state != S_HALT);

  // Enables are decoded from state, so an async reset drops them at once.
  assign we_mem = (r_state == S_EXEC) && (w_kind == K_SD);
  assign we_reg = w_rd_nz &&
                  (((r_state == S_EXEC) && ((w_kind == K_ADD) || (w_kind == K_SUB))) ||
                   ((r_state == S_MEM) && (w_kind == K_LD)));

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo: synchronous ROM model, directed and
// random programs checked against an instruction-level reference model.
module tb_uc_multiciclo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] pc;
  logic [31:0] instr;
  logic [63:0] Ra, Rb, Rw, C;
  logic        we_reg, we_mem, sinal, sel_mux1, sel_mux2, busy, illegal;

  int n_checks;
  int n_fail;

  logic [31:0] rom [0:255];

  typedef struct {
    bit     legal;
    int     lat;
    int     nreg;
    int     nmem;
    longint c;
    bit     sinal;
    bit     m1;
    bit     m2;
    int     ra;
    int     rb;
    int     rw;
  } exp_t;

  typedef struct {
    int          cycles;
    int          nreg;
    int          nmem;
    int          nboth;
    int          reg_cyc;
    int          mem_cyc;
    int          unstable;
    int          busy_low;
    bit          halted;
    logic [63:0] c, ra, rb, rw, pc_after;
    logic        sinal, m1, m2;
  } obs_t;

  uc_multiciclo #(.XLEN(64), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .instr(instr),
    .Ra(Ra), .Rb(Rb), .Rw(Rw), .C(C), .we_reg(we_reg), .we_mem(we_mem),
    .sinal(sinal), .sel_mux1(sel_mux1), .sel_mux2(sel_mux2),
    .busy(busy), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction ROM: data appears the cycle after pc.
  always @(posedge clk) instr <= rom[pc[9:2]];

  function automatic logic [31:0] enc_ld(input int rd, input int rs1, input int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i, 5'(rs1), 3'b011, 5'(rd), 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_sd(input int rs2, input int rs1, input int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i[11:5], 5'(rs2), 5'(rs1), 3'b011, i[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic longint sext12(input int x);
    int v;
    v = x;
    if (v >= 2048) v = v - 4096;
    return longint'(v);
  endfunction

  // Instruction-level expectation derived from the ISA subset rules.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int op, f3, f7, rd;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    rd = int'(w[11:7]);
    e = '{default: 0};
    e.ra = int'(w[19:15]);
    e.rb = int'(w[24:20]);
    e.rw = rd;
    e.m2 = 1'b1;
    e.legal = 1'b1;
    if (op == 'h03 && f3 == 3) begin
      e.lat = 5; e.nreg = (rd != 0) ? 1 : 0; e.m2 = 1'b0;
      e.c = sext12(int'(w[31:20]));
    end else if (op == 'h23 && f3 == 3) begin
      e.lat = 4; e.nmem = 1;
      e.c = sext12(int'({w[31:25], w[11:7]}));
    end else if (op == 'h33 && f3 == 0 && (f7 == 0 || f7 == 'h20)) begin
      e.lat = 4; e.nreg = (rd != 0) ? 1 : 0; e.m1 = 1'b1;
      e.sinal = (f7 == 'h20);
    end else begin
      e.legal = 1'b0; e.lat = 2;
    end
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes one instruction from its FETCH negedge until retire or halt.
  task automatic exec_one(output obs_t o);
    logic [63:0] pc0;
    pc0 = pc;
    o = '{default: 0};
    while (o.cycles < 20) begin
      o.cycles++;
      if (!busy) o.busy_low++;
      if (we_reg) begin o.nreg++; o.reg_cyc = o.cycles; end
      if (we_mem) begin o.nmem++; o.mem_cyc = o.cycles; end
      if (we_reg && we_mem) o.nboth++;
      if (o.cycles == 3) begin
        o.c = C; o.ra = Ra; o.rb = Rb; o.rw = Rw;
        o.sinal = sinal; o.m1 = sel_mux1; o.m2 = sel_mux2;
      end else if (o.cycles > 3 &&
                   (C !== o.c || Rw !== o.rw || Ra !== o.ra || Rb !== o.rb ||
                    sinal !== o.sinal || sel_mux1 !== o.m1 || sel_mux2 !== o.m2)) begin
        o.unstable++;
      end
      @(posedge clk);
      @(negedge clk);
      if (pc !== pc0) break;
      if (!busy) begin o.halted = 1'b1; break; end
    end
    o.pc_after = pc;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) rom[i] = 32'h00000013;
    rom[0] = enc_ld(7, 2, -1);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    n_checks++; if (pc !== 64'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
    n_checks++; if ({busy, illegal, we_reg, we_mem} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, illegal, we_reg, we_mem}); end
    n_checks++; if (Rw !== 64'd0 || C !== 64'd0) begin n_fail++; $display("FAIL reset_ir got Rw=%h C=%h want 0", Rw, C); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || pc !== 64'd0) begin n_fail++; $display("FAIL idle_no_start got busy=%b pc=%h want 0/0", busy, pc); end
    // Abort a load in MEM: enable and IR must clear asynchronously.
    start_pulse();
    repeat (4) @(negedge clk);
    n_checks++; if (we_reg !== 1'b1) begin n_fail++; $display("FAIL ld_mem_we got %b want 1", we_reg); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, we_reg, we_mem} !== 3'b000) begin n_fail++; $display("FAIL reset_in_mem got busy/we_reg/we_mem=%b want 000", {busy, we_reg, we_mem}); end
    n_checks++; if (Rw !== 64'd0 || C !== 64'd0 || pc !== 64'd0) begin n_fail++; $display("FAIL reset_in_mem_ir got Rw=%h C=%h pc=%h want 0", Rw, C, pc); end
    $display("test_reset: reset checked from IDLE and mid-LD");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_program(input string name, input logic [31:0] prog[$]);
    obs_t        o;
    exp_t        e;
    logic [63:0] pc_exp;
    for (int i = 0; i < 256; i++) rom[i] = 32'h00000013;
    foreach (prog[i]) rom[i] = prog[i];
    do_reset();
    start_pulse();
    pc_exp = 64'd0;
    foreach (prog[i]) begin
      e = model(prog[i]);
      exec_one(o);
      $display("%s: instr %h pc %h cycles %0d we_reg %0d we_mem %0d C %h", name, prog[i], pc_exp, o.cycles, o.nreg, o.nmem, o.c);
      n_checks++; if (o.cycles != e.lat || o.halted) begin n_fail++; $display("FAIL %s_latency[%0d] got %0d halted=%0d want %0d", name, i, o.cycles, o.halted, e.lat); end
      n_checks++; if (o.nreg != e.nreg || o.nmem != e.nmem || o.nboth != 0) begin n_fail++; $display("FAIL %s_enables[%0d] got reg=%0d mem=%0d both=%0d want reg=%0d mem=%0d", name, i, o.nreg, o.nmem, o.nboth, e.nreg, e.nmem); end
      if (e.nreg > 0) begin n_checks++; if (o.reg_cyc != e.lat) begin n_fail++; $display("FAIL %s_we_reg_cycle[%0d] got %0d want %0d", name, i, o.reg_cyc, e.lat); end end
      if (e.nmem > 0) begin n_checks++; if (o.mem_cyc != 4) begin n_fail++; $display("FAIL %s_we_mem_cycle[%0d] got %0d want 4", name, i, o.mem_cyc); end end
      n_checks++; if (o.c !== 64'(e.c)) begin n_fail++; $display("FAIL %s_imm[%0d] got %h want %h", name, i, o.c, 64'(e.c)); end
      n_checks++; if ({o.sinal, o.m1, o.m2} !== {e.sinal, e.m1, e.m2}) begin n_fail++; $display("FAIL %s_ctrl[%0d] got sinal/mux1/mux2=%b want %b", name, i, {o.sinal, o.m1, o.m2}, {e.sinal, e.m1, e.m2}); end
      n_checks++; if (o.ra !== 64'(e.ra) || o.rb !== 64'(e.rb) || o.rw !== 64'(e.rw)) begin n_fail++; $display("FAIL %s_regs[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", name, i, o.ra, o.rb, o.rw, e.ra, e.rb, e.rw); end
      n_checks++; if (o.unstable != 0 || o.busy_low != 0) begin n_fail++; $display("FAIL %s_stability[%0d] got unstable=%0d busy_low=%0d want 0/0", name, i, o.unstable, o.busy_low); end
      pc_exp = pc_exp + 64'd4;
      n_checks++; if (o.pc_after !== pc_exp) begin n_fail++; $display("FAIL %s_pc[%0d] got %h want %h", name, i, o.pc_after, pc_exp); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] p[$];
    p = {enc_ld(1, 0, 0), enc_r(7'h00, 3, 1, 2), enc_r(7'h20, 4, 6, 5),
         enc_sd(4, 0, 2), enc_ld(1, 5, -8), enc_r(7'h00, 0, 1, 2)};
    test_program("directed", p);
  endtask

  task automatic test_random();
    logic [31:0] p[$];
    int k;
    for (int i = 0; i < 30; i++) begin
      k = int'($urandom_range(0, 3));
      case (k)
        0: p.push_back(enc_ld(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 4095))));
        1: p.push_back(enc_sd(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 4095))));
        2: p.push_back(enc_r(7'h00, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31))));
        default: p.push_back(enc_r(7'h20, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31))));
      endcase
    end
    test_program("random", p);
  endtask

  task automatic test_illegal();
    logic [31:0] words[$];
    logic [31:0] w;
    exp_t        e;
    obs_t        o;
    words = {32'h00000013, enc_r(7'h01, 3, 1, 2), (enc_ld(2, 3, 8) & ~32'h00007000) | 32'h00002000};
    for (int i = 0; i < 3; i++) begin
      do begin
        w = $urandom;
        e = model(w);
      end while (e.legal);
      words.push_back(w);
    end
    foreach (words[i]) begin
      e = model(words[i]);
      for (int j = 0; j < 256; j++) rom[j] = 32'h00000013;
      rom[0] = enc_r(7'h00, 3, 1, 2);
      rom[1] = words[i];
      do_reset();
      start_pulse();
      exec_one(o);
      exec_one(o);
      $display("illegal: instr %h cycles %0d halted %0d illegal %b pc %h", words[i], o.cycles, o.halted, illegal, pc);
      n_checks++; if (!o.halted || o.cycles != e.lat) begin n_fail++; $display("FAIL illegal_halt[%0d] got halted=%0d cycles=%0d want 1/%0d", i, o.halted, o.cycles, e.lat); end
      n_checks++; if (illegal !== 1'b1 || busy !== 1'b0 || pc !== 64'd4) begin n_fail++; $display("FAIL illegal_state[%0d] got illegal=%b busy=%b pc=%h want 1/0/4", i, illegal, busy, pc); end
      n_checks++; if (o.nreg != 0 || o.nmem != 0) begin n_fail++; $display("FAIL illegal_enables[%0d] got reg=%0d mem=%0d want 0/0", i, o.nreg, o.nmem); end
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++; if ({illegal, busy, we_reg, we_mem} !== 4'b1000 || pc !== 64'd4) begin n_fail++; $display("FAIL halt_absorbing[%0d] got ill/busy/wr/wm=%b pc=%h want 1000/4", i, {illegal, busy, we_reg, we_mem}, pc); end
    end
  endtask

  task automatic test_reset_mid_sd();
    obs_t o;
    for (int i = 0; i < 256; i++) rom[i] = 32'h00000013;
    rom[0] = enc_r(7'h00, 3, 1, 2);
    rom[1] = enc_sd(4, 0, 2);
    do_reset();
    start_pulse();
    exec_one(o);
    repeat (3) @(negedge clk);
    n_checks++; if (we_mem !== 1'b1 || pc !== 64'd4) begin n_fail++; $display("FAIL sd_exec got we_mem=%b pc=%h want 1/4", we_mem, pc); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({we_mem, we_reg, busy, illegal} !== 4'b0000 || pc !== 64'd0) begin n_fail++; $display("FAIL reset_mid_sd got wm/wr/busy/ill=%b pc=%h want 0000/0", {we_mem, we_reg, busy, illegal}, pc); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({we_mem, we_reg, busy} !== 3'b000 || pc !== 64'd0) begin n_fail++; $display("FAIL after_reset_mid_sd got wm/wr/busy=%b pc=%h want 000/0", {we_mem, we_reg, busy}, pc); end
    $display("reset_mid_sd: reset asserted during SD EXEC");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_reset_mid_sd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
